// File: rtl/multicycle_maindec_pkg.sv
// Shared encodings for the multicycle main decoder: opcodes, FSM states, ALU/PC selects.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a. Optional MCDEC_LOGIC_IMM_EN adds andi/ori and the LIMMEX state.
package multicycle_maindec_pkg;

    // Instruction opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCDEC_LOGIC_IMM_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    // ALU operation class handed to the ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
`ifdef MCDEC_LOGIC_IMM_EN
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;
`endif

    // Next-PC source select
    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_IMMWB  = 4'd9,
        S_BEQ    = 4'd10,
        S_JMP    = 4'd11,
`ifdef MCDEC_LOGIC_IMM_EN
        S_LIMMEX = 4'd13,
`endif
        S_ERR    = 4'd12
    } state_t;

    // Per-state control word. fetch_strobe marks FETCH; ir_write and the
    // fetch-time pc_write are qualified with mem_ready at the top level.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       fetch_strobe;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       err;
    } ctrl_t;

    // States that wait on mem_ready and own the timeout counter
    function automatic logic is_wait_state(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Moore control word for a state; anything not named stays 0
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read     = 1'b1;
                c.fetch_strobe = 1'b1;
                c.alu_src_b    = ALUSRCB_FOUR;
                c.alu_op       = ALUOP_ADD;
                c.pc_src       = PCSRC_SEQ;
            end
            S_DECODE: begin
                c.alu_src_b = ALUSRCB_IMMSH;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_RTEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_IMMWB: c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALUSRCB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_src        = PCSRC_BRANCH;
            end
            S_JMP: begin
                c.pc_write = 1'b1;
                c.pc_src   = PCSRC_JUMP;
            end
`ifdef MCDEC_LOGIC_IMM_EN
            S_LIMMEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALUSRCB_IMM;
                c.alu_op    = ALUOP_LOGIC;
            end
`endif
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_maindec_mem_wait_timer.sv
// Counts consecutive mem_ready=0 cycles in a memory-wait state and flags the timeout.
// Latency: expired is combinational in the TIMEOUT-th idle cycle; counter updates on clk.
// Backpressure: none; ready=1 in the final cycle suppresses expired.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic ready,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    // Idle-cycle counter: held at zero outside waits and whenever the access completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else if (clr) begin
            cnt_q <= 8'd0;
        end else if (!ready) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // The cycle holding count TIMEOUT-1 is the last allowed idle cycle
    assign expired = !clr && !ready && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_maindec.sv
// Multicycle MIPS-style main control FSM (Moore, registered control word).
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles plus mem_ready wait cycles.
// Backpressure: stalls in FETCH/MEMRD/MEMWR until mem_ready; TIMEOUT idle cycles -> ERR. Option: MCDEC_LOGIC_IMM_EN.
module multicycle_maindec
    import multicycle_maindec_pkg::*;
#(
    parameter int TIMEOUT      = 15,
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       err,
    output logic [3:0] state_o
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q;
    logic   tmr_clr;
    logic   tmr_expired;

    // mem_ready always ends a wait, so it also restarts the count for the next wait state
    assign tmr_clr = !is_wait_state(state_q) || mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .ready   (mem_ready),
        .expired (tmr_expired)
    );

    // Next-state selection; mem_ready only matters in the three wait states
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)        state_d = S_DECODE;
                else if (tmr_expired) state_d = S_ERR;
            end
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = S_RTEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JMP;
`ifdef MCDEC_LOGIC_IMM_EN
                    OP_ANDI, OP_ORI: state_d = S_LIMMEX;
`endif
                    default:      state_d = (ILLEGAL_TRAP != 0) ? S_ERR : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)        state_d = S_MEMWB;
                else if (tmr_expired) state_d = S_ERR;
            end
            S_MEMWR: begin
                if (mem_ready)        state_d = S_FETCH;
                else if (tmr_expired) state_d = S_ERR;
            end
            S_RTEX:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_IMMWB;
`ifdef MCDEC_LOGIC_IMM_EN
            S_LIMMEX: state_d = S_IMMWB;
`endif
            S_MEMWB, S_ALUWB, S_IMMWB, S_BEQ, S_JMP: state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_ERR;
        endcase
    end

    // State and control word register together so outputs track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
        end
    end

    assign pc_write      = ctrl_q.pc_write | (ctrl_q.fetch_strobe & mem_ready);
    assign ir_write      = ctrl_q.fetch_strobe & mem_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_src        = ctrl_q.pc_src;
    assign err           = ctrl_q.err;
    assign state_o       = state_q;

endmodule

// File: doc/multicycle_maindec.md
MULTICYCLE_MAINDEC -- requirements
Module: multicycle_maindec

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles a memory state waits for mem_ready (range 1..255).
REQ-002 SHALL have parameter ILLEGAL_TRAP, default 1; when 1, an unknown opcode enters ERR, and when 0 it returns to FETCH.
REQ-003 SHALL have ports: clk, in, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, in, 1, the reset; it is asynchronous and active-low.
REQ-005 SHALL have ports op (in, 6, opcode) and mem_ready (in, 1, memory access complete).
REQ-006 SHALL have 1-bit outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write and alu_src_a.
REQ-007 SHALL have 2-bit outputs alu_src_b, alu_op and pc_src.
REQ-008 SHALL have 1-bit outputs err (sticky fault) and state_o (4-bit, current state encoding, for debug).

Function
REQ-009 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, ALUWB, ADDIEX, IMMWB, BEQ, JMP and ERR; all outputs decode from the state only.
REQ-010 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 and alu_op=00; ir_write and pc_write SHALL be 1 only in the cycle mem_ready=1.
REQ-011 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00, and SHALL branch on op: 000000 to RTEX, 100011 or 101011 to MEMADR, 000100 to BEQ, 001000 to ADDIEX, 000010 to JMP; any other op goes to ERR or FETCH per ILLEGAL_TRAP.
REQ-012 MEMADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEMRD for lw or MEMWR for sw.
REQ-013 MEMRD SHALL drive mem_read=1 and i_or_d=1, and SHALL go to MEMWB on mem_ready.
REQ-014 MEMWB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0.
REQ-015 MEMWR SHALL drive mem_write=1 and i_or_d=1, and SHALL go to FETCH on mem_ready.
REQ-016 RTEX SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10, then go to ALUWB; ALUWB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0.
REQ-017 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to IMMWB; IMMWB SHALL drive reg_write=1 and reg_dst=0.
REQ-018 BEQ SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_src=01; JMP SHALL drive pc_write=1 and pc_src=10.
REQ-019 MEMWB, ALUWB, IMMWB, BEQ and JMP SHALL each last one cycle and return to FETCH.
REQ-020 Outputs not listed for a state SHALL be 0; there are no X values.
REQ-021 Latency SHALL be lw 5, sw 4, R/addi 4, beq/j 3 cycles, plus mem wait cycles.
REQ-022 A wait counter SHALL clear on entry to FETCH, MEMRD and MEMWR and increment each cycle mem_ready=0; at TIMEOUT with mem_ready still 0 the FSM goes to ERR.
REQ-023 mem_ready=1 in the timeout cycle SHALL win over the timeout.
REQ-024 mem_ready SHALL be ignored outside FETCH, MEMRD and MEMWR.
REQ-025 ERR SHALL assert err=1 with all control outputs 0 and SHALL be left only by reset.

Reset
REQ-026 rst_n=0 SHALL immediately force state FETCH, clear the wait counter and clear err, including mid-instruction and mid-wait.
REQ-027 The first FETCH after rst_n deasserts SHALL begin at the next rising clk edge.

Configuration
REQ-028 With MCDEC_LOGIC_IMM_EN defined, DECODE SHALL route andi (001100) and ori (001101) to a state LIMMEX (alu_src_a=1, alu_src_b=10, alu_op=11), then to IMMWB.
REQ-029 Without MCDEC_LOGIC_IMM_EN, andi and ori SHALL be treated as illegal, and the state and alu_op=11 encodings SHALL be unused.

Structure
REQ-030 A shared package SHALL hold the opcode constants, state encodings, and the alu_op and pc_src constants.
REQ-031 The wait/timeout counter SHALL be a sub-module mem_wait_timer (ports clk, rst_n, clr, ready, expired).

Verification
REQ-032 Bench SHALL cover reset then lw with mem_ready tied 1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; reg_write=1 only in cycle 5.
REQ-033 Bench SHALL cover beq with mem_ready=1: pc_write_cond=1 with pc_src=01 in cycle 3, then FETCH.
REQ-034 Bench SHALL cover sw with mem_ready held 0 for 3 cycles in MEMWR: mem_write=1 for 4 cycles, then FETCH, err=0.
REQ-035 Bench SHALL cover TIMEOUT=4 with mem_ready held 0 in FETCH: ERR after 4 wait cycles, err=1 sticky until rst_n.
REQ-036 Bench SHALL cover op=111111 with ILLEGAL_TRAP=1 (goes to ERR) and with ILLEGAL_TRAP=0 (FETCH the cycle after DECODE).
REQ-037 Bench SHALL cover rst_n asserted asynchronously during MEMRD: state_o equals the FETCH encoding before the next clk edge, and all outputs are at FETCH values.
